ov7670_dvp_emulator: RTL

// Transmit side of the OV7670 DVP pixel bus. Reads RGB444 pixels from the frame

---
 rtl/ov7670_dvp_emulator_if.sv | 22 ++
 rtl/ov7670_dvp_emulator.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ov7670_dvp_emulator_if.sv
// DVP emulator bus bundle: the frame-buffer read port plus the OV7670-style
// byte bus. The emulator is the master. The slave side supplies rd_data and
// consumes vsync/href/d, typically a frame buffer plus the capture block.
//   rd_addr  linear pixel index of the read
//   rd_en    one-pclk read strobe
//   rd_data  {R,G,B} RGB444, valid exactly one pclk after rd_en
//   vsync    high during the vsync lines
//   href     high while d carries active bytes
//   d        pixel byte, zero whenever href is low
interface ov7670_dvp_emulator_if #(
  parameter int ADDR_W = 19
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [11:0]       rd_data;
  logic              vsync;
  logic              href;
  logic [7:0]        d;

  modport master (output rd_addr, rd_en, vsync, href, d, input rd_data);
  modport slave  (input rd_addr, rd_en, vsync, href, d, output rd_data);
endinterface

// File: rtl/ov7670_dvp_emulator.sv
// OV7670 DVP transmit emulator. Replays RGB444 pixels from a frame buffer as an
// RGB565 byte stream with OV7670 frame timing. It is used for camera-less
// loopback of the capture path.
//   pclk        pixel clock, rising edge
//   rst         synchronous active-high reset, aborts any frame in flight
//   en          level; a frame starts from IDLE while en=1, and back-to-back
//               frames continue while en stays high at the end of each frame
//   frame_done  one-cycle pulse on the last cycle of the last front-porch line
//   bus         master side of ov7670_dvp_emulator_if
// All outputs are registered. The output for line cycle h is produced from the
// counter value h, so the outputs lag the timebase by exactly one cycle.
module ov7670_dvp_emulator #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 17,
  parameter int V_FP     = 10,
  parameter int ADDR_W   = 19
) (
  input  logic pclk,
  input  logic rst,
  input  logic en,
  output logic frame_done,
  ov7670_dvp_emulator_if.master bus
);
  localparam int LINE  = 2*H_ACTIVE + H_BLANK;
  localparam int VM1   = (V_SYNC > V_BP) ? V_SYNC : V_BP;
  localparam int VM2   = (V_ACTIVE > V_FP) ? V_ACTIVE : V_FP;
  localparam int V_MAX = (VM1 > VM2) ? VM1 : VM2;
  localparam int H_W   = $clog2(LINE);
  localparam int V_W   = $clog2(V_MAX + 1);

  localparam logic [H_W-1:0] H_END    = H_W'(LINE - 1);
  localparam logic [H_W-1:0] H_PRE    = H_W'(LINE - 2);
  localparam logic [H_W-1:0] H_ACT    = H_W'(2*H_ACTIVE);
  localparam logic [H_W-1:0] H_RD_END = H_W'(2*H_ACTIVE - 2);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

  state_t            state, nxt_state;
  logic [H_W-1:0]    h_cnt;
  logic [V_W-1:0]    v_cnt, v_last;
  logic [ADDR_W-1:0] pix;
  logic [7:0]        hold_b1;
  logic              line_end, seg_end, in_href, next_act, do_rd;
  logic [7:0]        b0, b1;

  // Segment length and successor for the current state.
  always_comb begin
    v_last    = '0;
    nxt_state = IDLE;
    unique case (state)
      VSYNC:   begin v_last = V_W'(V_SYNC - 1);   nxt_state = VBP;    end
      VBP:     begin v_last = V_W'(V_BP - 1);     nxt_state = ACTIVE; end
      ACTIVE:  begin v_last = V_W'(V_ACTIVE - 1); nxt_state = VFP;    end
      VFP:     begin v_last = V_W'(V_FP - 1);     nxt_state = en ? VSYNC : IDLE; end
      default: begin v_last = '0;                 nxt_state = en ? VSYNC : IDLE; end
    endcase
  end

  assign line_end = (h_cnt == H_END);
  assign seg_end  = (v_cnt == v_last);
  assign in_href  = (state == ACTIVE) && (h_cnt < H_ACT);
  // The line after this one carries pixels.
  assign next_act = ((state == VBP) && seg_end) || ((state == ACTIVE) && !seg_end);

  // A pixel is fetched two cycles ahead of its byte0. Pixel k of a line is
  // read at line cycle 2k-2. Pixel 0 is therefore read at cycle LINE-2 of the
  // preceding line. For the first active line, that read falls in the tail of
  // the last back-porch line. This requires H_BLANK >= 2.
  assign do_rd = ((state == ACTIVE) && !h_cnt[0] && (h_cnt < H_RD_END)) ||
                 ((h_cnt == H_PRE) && next_act);

  // RGB444 -> RGB565 with MSB replication, split into the two bus bytes:
  //   byte0 = {R,R[3],G[3:1]}   byte1 = {G[0],G[3:2],B,B[3]}
  assign b0 = {bus.rd_data[11:8], bus.rd_data[11], bus.rd_data[7:5]};
  assign b1 = {bus.rd_data[4], bus.rd_data[7:6], bus.rd_data[3:0], bus.rd_data[3]};

  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      pix         <= '0;
      hold_b1     <= '0;
      frame_done  <= 1'b0;
      bus.vsync   <= 1'b0;
      bus.href    <= 1'b0;
      bus.d       <= '0;
      bus.rd_en   <= 1'b0;
      bus.rd_addr <= '0;
    end else begin
      bus.vsync  <= (state == VSYNC);
      bus.href   <= in_href;
      frame_done <= (state == VFP) && seg_end && line_end;

      // rd_data is valid on even active bytes. Emit byte0 directly and keep
      // the pixel's byte1 for the following cycle.
      if (in_href) begin
        if (!h_cnt[0]) begin
          bus.d   <= b0;
          hold_b1 <= b1;
        end else begin
          bus.d   <= hold_b1;
        end
      end else begin
        bus.d <= 8'h00;
      end

      bus.rd_en <= do_rd;
      if (do_rd) begin
        bus.rd_addr <= pix;
        pix         <= pix + ADDR_W'(1);
      end else if (state == IDLE || state == VSYNC) begin
        pix <= '0;
      end

      if (state == IDLE) begin
        h_cnt <= '0;
        v_cnt <= '0;
        if (en) state <= VSYNC;
      end else if (line_end) begin
        h_cnt <= '0;
        if (seg_end) begin
          v_cnt <= '0;
          state <= nxt_state;
        end else begin
          v_cnt <= v_cnt + V_W'(1);
        end
      end else begin
        h_cnt <= h_cnt + H_W'(1);
      end
    end
  end
endmodule
